// File: rtl/reg_file_pkg.sv
// Shared types and constants for the two-read, one-write MIPS register file.
package reg_file_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned REG_ZERO   = 0;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// Combinational read port: address mux, $zero override and, when
// REG_FILE_BYPASS_EN is defined, write-through forwarding from the write port.
import reg_file_pkg::*;

module reg_file_rd_port #(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
`ifdef REG_FILE_BYPASS_EN
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
`endif
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rd
);

    always_comb begin
        rd = regs[addr];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && (wa != ADDR_W'(REG_ZERO)) && (addr == wa)) begin
            rd = wd;
        end
`endif
        if (addr == ADDR_W'(REG_ZERO)) begin
            rd = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// MIPS general-purpose register file: two combinational reads, one clocked write.
// Optional write-through forwarding is enabled by defining REG_FILE_BYPASS_EN.
import reg_file_pkg::*;

module reg_file #(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] wa,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic              en
);

    localparam int unsigned NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (en && (wa != ADDR_W'(REG_ZERO))) begin
            regs[wa] <= wd;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // Forwarding must stay silent while reset holds the outputs at zero.
    logic byp_en;
    always_comb byp_en = en & rst_n;
`endif

    reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
`ifdef REG_FILE_BYPASS_EN
        .wr_en (byp_en),
        .wa    (wa),
        .wd    (wd),
`endif
        .regs  (regs),
        .addr  (a1),
        .rd    (r1)
    );

    reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
`ifdef REG_FILE_BYPASS_EN
        .wr_en (byp_en),
        .wa    (wa),
        .wd    (wd),
`endif
        .regs  (regs),
        .addr  (a2),
        .rd    (r2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, multi-cycle corner
// sequences and randomized traffic against an array-based reference model.
module tb_reg_file;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] r1, r2, wd;
    logic [4:0]  wa, a1, a2;
    logic        en;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [32];

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .r1(r1), .r2(r2),
        .wd(wd), .wa(wa), .a1(a1), .a2(a2), .en(en)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        en;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] pre_r1;   // stored-contents value before the edge
        logic [31:0] pre_r2;
        logic [31:0] post_r1;
        logic [31:0] post_r2;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [4:0] w, input logic [31:0] d,
                         input logic [4:0] x1, input logic [4:0] x2);
        en = e; wa = w; wd = d; a1 = x1; a2 = x2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected read value from the spec rules: $zero, optional forwarding, storage.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (BYP && en && rst_n && wa != 5'd0 && a == wa) return wd;
        return mdl[a];
    endfunction

    function automatic logic [31:0] fwd(input vec_t v, input logic [4:0] a, input logic [31:0] stored);
        if (BYP && v.en && v.wa != 5'd0 && a == v.wa && a != 5'd0) return v.wd;
        return stored;
    endfunction

    vec_t vecs [5];

    initial begin
        vecs[0] = '{1'b1, 5'd0, 32'h0000FFFF, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 5'd2, 32'h0000FFF0, 5'd0, 5'd2, 32'h0, 32'h0, 32'h0, 32'h0000FFF0};
        vecs[2] = '{1'b1, 5'd1, 32'h00001000, 5'd2, 5'd1, 32'h0000FFF0, 32'h0, 32'h0000FFF0, 32'h00001000};
        vecs[3] = '{1'b0, 5'd1, 32'hDEADBEEF, 5'd2, 5'd1, 32'h0000FFF0, 32'h00001000, 32'h0000FFF0, 32'h00001000};
        vecs[4] = '{1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd2, 32'h0, 32'h0000FFF0, 32'hA5A5A5A5, 32'h0000FFF0};

        // Reset from time zero, with a write attempted during reset.
        rst_n = 1'b0;
        drive(1'b1, 5'd5, 32'h12345678, 5'd5, 5'd31);
        #3;
        check("reset_r1", r1, 32'h0);
        check("reset_r2", r2, 32'h0);
        tick;
        check("reset_wr_blocked_r1", r1, 32'h0);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        #2;
        check("after_reset_r1", r1, 32'h0);
        check("after_reset_r2", r2, 32'h0);
        tick;

        // Directed vector table.
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].wa, vecs[i].wd, vecs[i].a1, vecs[i].a2);
            #2;
            check($sformatf("vec%0d_pre_r1", i), r1, fwd(vecs[i], vecs[i].a1, vecs[i].pre_r1));
            check($sformatf("vec%0d_pre_r2", i), r2, fwd(vecs[i], vecs[i].a2, vecs[i].pre_r2));
            tick;
            check($sformatf("vec%0d_post_r1", i), r1, vecs[i].post_r1);
            check($sformatf("vec%0d_post_r2", i), r2, vecs[i].post_r2);
        end

        // Full sweep: write every register, read back on both ports.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
            tick;
        end
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'(31 - i);
            #1;
            check($sformatf("sweep_r1_%0d", i), r1, 32'(i) * 32'h01010101);
            check($sformatf("sweep_r2_%0d", 31 - i), r2, 32'(31 - i) * 32'h01010101);
        end

        // Asynchronous reset between edges clears everything immediately.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        drive(1'b1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd31);
        #1;
        check("async_rst_bypass_r1", r1, 32'h0);
        check("async_rst_r2", r2, 32'h0);
        tick;
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 1; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'(i);
            #1;
            check($sformatf("post_rst_r1_%0d", i), r1, 32'h0);
            check($sformatf("post_rst_r2_%0d", i), r2, 32'h0);
        end

        // First write after reset release lands at the next edge.
        tick;
        drive(1'b1, 5'd9, 32'h0BADF00D, 5'd9, 5'd9);
        tick;
        en = 1'b0;
        #1;
        check("first_wr_after_rst", r1, 32'h0BADF00D);

        // Randomized traffic against the array model, with occasional async resets.
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mdl[9] = 32'h0BADF00D;
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) a2 = wa;
            #2;
            check("rand_pre_r1", r1, exp_rd(a1));
            check("rand_pre_r2", r2, exp_rd(a2));
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                for (int k = 0; k < 32; k++) mdl[k] = 32'h0;
                #1;
                check("rand_rst_r1", r1, 32'h0);
                check("rand_rst_r2", r2, 32'h0);
                tick;
                rst_n = 1'b1;
            end else begin
                tick;
                if (en && wa != 5'd0) mdl[wa] = wd;
                check("rand_post_r1", r1, exp_rd(a1));
                check("rand_post_r2", r2, exp_rd(a2));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
